dft_sample_buffer: RTL
======================

# dft_sample_buffer

Input sample buffer directly upstream of the DFT control FSM. Accepts a stream of time-domain samples over a valid/ready handshake and writes them into a 4096-entry sample RAM. Once `sample_num` samples are stored it raises `data_loaded` and serves random reads at `read_adr` to the compute path. It refuses new input until the FSM has finished computing on the stored frame.

## Interface

Parameters:
- `DATA_W`, 16, sample width in bits
- `ADDR_W`, 12, address width; depth = 2^ADDR_W = 4096

Ports:
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-low
- `ce`  in  1  clock enable; when low all state, RAM writes and the read register hold
- `sample_num`  in  12  frame length; 0 means 4096; latched on entry to FILL
- `in_valid`  in  1  upstream sample valid
- `in_data`  in  DATA_W  upstream sample
- `in_ready`  out  1  buffer accepts a sample this cycle
- `load_nCompute`  in  1  from FSM: 1 = load phase, 0 = compute in progress
- `read_adr`  in  12  read address from FSM/compute path
- `read_data`  out  DATA_W  registered RAM read data
- `data_loaded`  out  1  full frame stored, level
- `fill_level`  out  13  samples stored in the current frame, 0..4096
- `protocol_err`  out  1  sticky error flag

## Operation

- States: FILL, FULL, BUSY. Reset enters FILL.
- FILL:
  - `in_ready`=1.
  - A transfer is `in_valid & in_ready & ce`. Each transfer writes `in_data` to RAM[wr_adr], increments wr_adr and `fill_level`.
  - When the transfer writes address `sample_num_l - 1` (mod 4096), go to FULL.
- FULL:
  - `in_ready`=0 and `data_loaded`=1. Upstream is held off; no data is dropped.
  - When `load_nCompute`=0, go to BUSY.
- BUSY:
  - `in_ready`=0 and `data_loaded`=0. RAM contents are frozen.
  - When `load_nCompute`=1, go to FILL. On that transition, clear wr_adr and `fill_level` and re-latch `sample_num`.
- `load_nCompute`=0 while in FILL is a protocol violation:
  - Set `protocol_err`. It clears only on reset.
  - The state does not change.
- `sample_num` changes during FILL, FULL or BUSY have no effect until the next FILL entry.
- The read port is always active. RAM reads during FILL return whatever is stored, including stale data.
- Read and write to the same address in the same cycle return the old data (read-first).
- `fill_level` is 13 bits so that a 4096-sample frame reads 4096. wr_adr is 12 bits and wraps to 0 after 4095.

## Timing

- Reset values:
  - state=FILL, `sample_num_l`=`sample_num`, wr_adr=0, `fill_level`=0
  - `data_loaded`=0, `protocol_err`=0, `read_data`=0
  - `in_ready`=1, since it is decoded from state
- `in_ready` and `data_loaded` are decoded combinationally from the state register; no input-to-output combinational path.
- Read latency is 1 `ce` cycle: `read_adr` sampled at edge N appears on `read_data` after edge N.
- `data_loaded` rises in the cycle after the last write edge. It falls in the cycle after the edge where `load_nCompute`=0 is sampled in FULL.
- `in_ready` rises in the cycle after `load_nCompute`=1 is sampled in BUSY.
- With `ce`=0, no transfer occurs even if `in_valid & in_ready`. Upstream must hold `in_data` until a `ce` cycle.
- Reset mid-fill discards the partial frame; `fill_level` returns to 0. RAM contents are not cleared.

## Structure

- `dft_pkg` holds `DATA_W`, `ADDR_W`, `DEPTH` and the state enum `buf_state_t` {FILL, FULL, BUSY}, shared with the DFT FSM.
- Sub-module `sample_ram`:
  - Simple dual-port: one write port, one read port with synchronous read-first behaviour and `ce` gating.
  - Instantiated once.
- Top level holds the state register, write counter, `sample_num` latch and error flag.

## Test plan

- Reset, `sample_num`=8, stream 0x0001..0x0008 with continuous `in_valid` -> 8 transfers, `data_loaded`=1 the cycle after the 8th, `in_ready`=0, `fill_level`=8. Reads of addresses 0..7 return 0x0001..0x0008 one cycle later.
- In FULL, hold `in_valid`=1 with data 0xDEAD for 20 cycles -> no writes, `fill_level` stays 8. Drop `load_nCompute` -> `data_loaded`=0 next cycle. Raise it -> `in_ready`=1 and `fill_level`=0. Next frame starts at address 0.
- `sample_num`=0, stream 4096 samples -> `data_loaded` after the 4096th, `fill_level`=4096, wr_adr wrapped to 0.
- Toggle `ce` 1/0 every cycle while streaming 4 samples with `sample_num`=4 -> exactly 4 writes, all on `ce`=1 cycles. `read_data` changes only on `ce` edges.
- Pull `load_nCompute` low during FILL after 3 of 8 samples -> `protocol_err`=1 and stays set. Fill continues to 8. `nrst` low for 1 cycle -> `protocol_err`=0, `fill_level`=0.
- Change `sample_num` from 8 to 4 after 2 samples -> fill still ends at 8. The next frame uses 4.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared constants and the buffer state encoding, common to the sample buffer and the DFT FSM.
package dft_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    BUSY = 2'd2
  } buf_state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: one write port and one registered, read-first read port.
// The clock enable gates both writes and the read register.
module sample_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH_L = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH_L];

  // Write port; storage is never cleared, so stale data survives reset.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      mem[wr_adr] <= wr_data;
    end
  end

  // Read register; sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if (ce) begin
      rd_data <= mem[rd_adr];
    end
  end

endmodule

// File: rtl/dft_sample_buffer.sv
// Input sample buffer ahead of the DFT control FSM: fills a frame over valid/ready,
// holds it for the compute phase, and serves random reads throughout.
module dft_sample_buffer #(
  parameter int unsigned DATA_W = dft_pkg::DATA_W,
  parameter int unsigned ADDR_W = dft_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              load_nCompute,
  input  logic [ADDR_W-1:0] read_adr,
  output logic [DATA_W-1:0] read_data,
  output logic              data_loaded,
  output logic [ADDR_W:0]   fill_level,
  output logic              protocol_err
);

  import dft_pkg::*;

  buf_state_t        state;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] sample_num_l;
  logic              xfer_c;
  logic [ADDR_W-1:0] last_adr_c;

  // Handshake flags decode straight from the state register.
  assign in_ready    = (state == FILL);
  assign data_loaded = (state == FULL);

  // A length of 0 wraps to 4095 here, which is exactly the 4096-sample frame.
  assign last_adr_c = sample_num_l - ADDR_W'(1);
  assign xfer_c     = in_valid & in_ready & ce;

  // Frame state, write pointer, length latch and sticky error flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= FILL;
      sample_num_l <= sample_num;
      wr_adr       <= '0;
      fill_level   <= '0;
      protocol_err <= 1'b0;
    end else if (ce) begin
      unique case (state)
        FILL: begin
          if (!load_nCompute) begin
            protocol_err <= 1'b1;
          end
          if (in_valid) begin
            wr_adr     <= wr_adr + ADDR_W'(1);
            fill_level <= fill_level + (ADDR_W + 1)'(1);
            if (wr_adr == last_adr_c) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (!load_nCompute) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (load_nCompute) begin
            state        <= FILL;
            wr_adr       <= '0;
            fill_level   <= '0;
            sample_num_l <= sample_num;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sample_ram (
    .clk     (clk),
    .nrst    (nrst),
    .ce      (ce),
    .we      (xfer_c & nrst),
    .wr_adr  (wr_adr),
    .wr_data (in_data),
    .rd_adr  (read_adr),
    .rd_data (read_data)
  );

endmodule
